ebus_xfer: RTL and testbench

//  EBOX-side EBUS transfer sequencer, directly downstream of the EBOX I/O-instruction microcode.

---
 rtl/ebus_pkg.sv | 32 +++
 rtl/ebus_sync2.sv | 25 ++
 rtl/ebus_xfer.sv | 198 +++++++++++++++++++
 tb/tb_ebus_xfer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebus_pkg.sv
// ebus_pkg - shared types and widths for the EBOX-side EBUS transfer sequencer.
//   ebusFuncT  : EBUS function codes driven on ebusFunc
//   ebusStateT : sequencer states
//   EBUS_CS_W / EBUS_FUNC_W / EBUS_DATA_W : bus field widths (data bit 0 is the MSB)
package ebus_pkg;

  localparam int EBUS_CS_W   = 7;
  localparam int EBUS_FUNC_W = 3;
  localparam int EBUS_DATA_W = 36;

  typedef enum logic [EBUS_FUNC_W-1:0] {
    EBUS_CONI  = 3'd0,
    EBUS_CONO  = 3'd1,
    EBUS_DATAI = 3'd2,
    EBUS_DATAO = 3'd3
  } ebusFuncT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SETUP,
    ST_DEMAND,
    ST_RELEASE,
    ST_DONE
  } ebusStateT;

  // CONO and DATAO put data on the bus; everything else is a read.
  function automatic logic func_is_write(input logic [EBUS_FUNC_W-1:0] f);
    return (f == EBUS_CONO) || (f == EBUS_DATAO);
  endfunction

endpackage

// File: rtl/ebus_sync2.sv
// ebus_sync2 - two-flop synchroniser for the device XFER acknowledge.
//   clk   : EBOX clock
//   rst_n : async active-low reset, output resets low
//   d     : asynchronous input
//   q     : synchronised output (two clocks of latency)
module ebus_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/ebus_xfer.sv
// ebus_xfer - EBOX-side EBUS transfer sequencer.
// Turns one CONO/CONI/DATAO/DATAI request from the EBOX microcode into a full
// EBUS cycle: arbitrate, drive CS/FUNC (and data for writes), raise DEMAND,
// wait for the device XFER, latch read data and report done/timeout.
//
// Ports
//   clk, rst_n                 : EBOX clock, async active-low reset
//   ioReq/ioFunc/ioCS/ioDataOut: EBOX request (sampled only while idle)
//   ioBusy/ioDone/ioTimeout    : status back to the EBOX
//   ioDataIn                   : read result, held until the next accepted request
//   ebusReq/ebusGrant          : bus arbitration
//   ebusCS/ebusFunc/ebusDemand : bus control
//   ebusXfer                   : device acknowledge (asynchronous)
//   ebusDataOE/ebusDataOut     : write data and its output enable
//   ebusDataIn                 : read data
// Build option EBUS_PARITY_EN adds ebusParOut, ebusParIn and ioParErr
// (odd parity over the 36 data bits).
module ebus_xfer
  import ebus_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int HOLD_CYCLES    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ioReq,
  input  logic [EBUS_FUNC_W-1:0] ioFunc,
  input  logic [EBUS_CS_W-1:0]   ioCS,
  input  logic [0:EBUS_DATA_W-1] ioDataOut,
  output logic                   ioBusy,
  output logic                   ioDone,
  output logic                   ioTimeout,
  output logic [0:EBUS_DATA_W-1] ioDataIn,
  output logic                   ebusReq,
  input  logic                   ebusGrant,
  output logic [EBUS_CS_W-1:0]   ebusCS,
  output logic [EBUS_FUNC_W-1:0] ebusFunc,
  output logic                   ebusDemand,
  input  logic                   ebusXfer,
  output logic                   ebusDataOE,
  output logic [0:EBUS_DATA_W-1] ebusDataOut,
  input  logic [0:EBUS_DATA_W-1] ebusDataIn
`ifdef EBUS_PARITY_EN
  ,
  output logic                   ebusParOut,
  input  logic                   ebusParIn,
  output logic                   ioParErr
`endif
);

  // One counter is shared by setup, timeout and hold, so size it for the largest.
  localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CNT = (TIMEOUT_CYCLES > MAX_SH) ? TIMEOUT_CYCLES : MAX_SH;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_CNT     = CNT_W'(HOLD_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ebusStateT              state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [EBUS_FUNC_W-1:0] func_reg;
  logic [EBUS_CS_W-1:0]   cs_reg;
  logic [0:EBUS_DATA_W-1] data_reg;
  logic                   wr_reg;
  logic                   to_reg;
  logic                   xfer_sync;

  ebus_sync2 u_xfer_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ebusXfer),
    .q     (xfer_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      func_reg    <= '0;
      cs_reg      <= '0;
      data_reg    <= '0;
      wr_reg      <= 1'b0;
      to_reg      <= 1'b0;
      ioBusy      <= 1'b0;
      ioDone      <= 1'b0;
      ioTimeout   <= 1'b0;
      ioDataIn    <= '0;
      ebusReq     <= 1'b0;
      ebusCS      <= '0;
      ebusFunc    <= '0;
      ebusDemand  <= 1'b0;
      ebusDataOE  <= 1'b0;
      ebusDataOut <= '0;
    end else begin
      // Completion status is a single-clock pulse.
      ioDone    <= 1'b0;
      ioTimeout <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (ioReq) begin
            func_reg  <= ioFunc;
            cs_reg    <= ioCS;
            data_reg  <= ioDataOut;
            wr_reg    <= func_is_write(ioFunc);
            to_reg    <= 1'b0;
            cnt_reg   <= '0;
            ioDataIn  <= '0;
            ioBusy    <= 1'b1;
            ebusReq   <= 1'b1;
            state_reg <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (ebusGrant) begin
            ebusCS      <= cs_reg;
            ebusFunc    <= func_reg;
            ebusDataOE  <= wr_reg;
            ebusDataOut <= wr_reg ? data_reg : '0;
            cnt_reg     <= '0;
            state_reg   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_reg >= SETUP_LAST) begin
            ebusDemand <= 1'b1;
            cnt_reg    <= '0;
            state_reg  <= ST_DEMAND;
          end else begin
            cnt_reg <= sat_inc(cnt_reg);
          end
        end
        ST_DEMAND: begin
          // XFER is checked first so it wins over a simultaneous timeout.
          if (xfer_sync) begin
            if (!wr_reg) ioDataIn <= ebusDataIn;
            ebusDemand <= 1'b0;
            cnt_reg    <= '0;
            state_reg  <= ST_RELEASE;
          end else if (cnt_reg >= TIMEOUT_LAST) begin
            to_reg     <= 1'b1;
            ebusDemand <= 1'b0;
            cnt_reg    <= '0;
            state_reg  <= ST_RELEASE;
          end else begin
            cnt_reg <= sat_inc(cnt_reg);
          end
        end
        ST_RELEASE: begin
          // A silent device never drops XFER handshake, so skip that wait on timeout.
          if (to_reg || !xfer_sync) begin
            if (cnt_reg >= HOLD_CNT) begin
              ioDone    <= 1'b1;
              ioTimeout <= to_reg;
              state_reg <= ST_DONE;
            end else begin
              cnt_reg <= sat_inc(cnt_reg);
            end
          end
        end
        ST_DONE: begin
          ioBusy      <= 1'b0;
          ebusReq     <= 1'b0;
          ebusCS      <= '0;
          ebusFunc    <= '0;
          ebusDataOE  <= 1'b0;
          ebusDataOut <= '0;
          state_reg   <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef EBUS_PARITY_EN
  logic par_err_reg;

  // Error flag is captured with the read data and presented alongside ioDone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && ioReq) begin
      par_err_reg <= 1'b0;
    end else if (state_reg == ST_DEMAND && xfer_sync && !wr_reg) begin
      par_err_reg <= ~((^ebusDataIn) ^ ebusParIn);
    end
  end

  assign ioParErr   = ioDone & par_err_reg;
  assign ebusParOut = ebusDataOE & ~(^ebusDataOut);
`endif

endmodule

// File: tb/tb_ebus_xfer.sv
// tb_ebus_xfer - scoreboard bench for ebus_xfer.
// Stimulus pushes the expected completion into sb_q; the monitor pops and
// compares whenever ioDone is seen. Build with EBUS_PARITY_EN to also cover
// the parity ports.
module tb_ebus_xfer;
  import ebus_pkg::*;

  localparam int SETUP   = 2;
  localparam int TIMEOUT = 256;
  localparam int HOLD    = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ioReq;
  logic [2:0]  ioFunc;
  logic [6:0]  ioCS;
  logic [0:35] ioDataOut;
  logic        ioBusy, ioDone, ioTimeout;
  logic [0:35] ioDataIn;
  logic        ebusReq, ebusGrant;
  logic [6:0]  ebusCS;
  logic [2:0]  ebusFunc;
  logic        ebusDemand, ebusXfer, ebusDataOE;
  logic [0:35] ebusDataOut, ebusDataIn;
`ifdef EBUS_PARITY_EN
  logic        ebusParOut, ebusParIn, ioParErr;
`endif

  always #5 clk = ~clk;

  ebus_xfer #(
    .SETUP_CYCLES   (SETUP),
    .TIMEOUT_CYCLES (TIMEOUT),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ioReq       (ioReq),
    .ioFunc      (ioFunc),
    .ioCS        (ioCS),
    .ioDataOut   (ioDataOut),
    .ioBusy      (ioBusy),
    .ioDone      (ioDone),
    .ioTimeout   (ioTimeout),
    .ioDataIn    (ioDataIn),
    .ebusReq     (ebusReq),
    .ebusGrant   (ebusGrant),
    .ebusCS      (ebusCS),
    .ebusFunc    (ebusFunc),
    .ebusDemand  (ebusDemand),
    .ebusXfer    (ebusXfer),
    .ebusDataOE  (ebusDataOE),
    .ebusDataOut (ebusDataOut),
    .ebusDataIn  (ebusDataIn)
`ifdef EBUS_PARITY_EN
    ,
    .ebusParOut  (ebusParOut),
    .ebusParIn   (ebusParIn),
    .ioParErr    (ioParErr)
`endif
  );

  typedef struct {
    logic        rd;
    logic [0:35] data;
    logic        to;
    logic        pe;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  // Device model controls
  logic        dev_en = 1'b0;
  int          dev_delay = 0;
  logic [0:35] dev_data = '0;
  logic        dev_par = 1'b0;

  // Per-transaction observations
  int   lat, dwidth;
  logic stable_bad, oe_seen, arb_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    logic r;
    r = ioBusy | ioDone | ioTimeout | (|ioDataIn) | ebusReq | (|ebusCS) |
        (|ebusFunc) | ebusDemand | ebusDataOE | (|ebusDataOut);
`ifdef EBUS_PARITY_EN
    r = r | ebusParOut | ioParErr;
`endif
    return r;
  endfunction

  // Device: raises XFER dev_delay clocks after DEMAND is seen, drops it once DEMAND falls.
  initial begin
    int dcnt;
    dcnt = 0;
    ebusXfer = 1'b0;
    ebusDataIn = '0;
`ifdef EBUS_PARITY_EN
    ebusParIn = 1'b0;
`endif
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ebusXfer = 1'b0;
        dcnt = 0;
      end else if (ebusDemand) begin
        if (dev_en && dcnt == dev_delay) begin
          ebusXfer = 1'b1;
          ebusDataIn = dev_data;
`ifdef EBUS_PARITY_EN
          ebusParIn = dev_par;
`endif
        end
        dcnt++;
      end else begin
        ebusXfer = 1'b0;
        dcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every ioDone.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (ioDone) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'(ioDone), 64'(0));
        end else begin
          e = sb_q.pop_front();
          chk("io_timeout", 64'(ioTimeout), 64'(e.to));
          if (e.rd) chk("io_data_in", 64'(ioDataIn), 64'(e.data));
`ifdef EBUS_PARITY_EN
          chk("io_par_err", 64'(ioParErr), 64'(e.pe));
`endif
        end
      end
    end
  end

  task automatic run_xfer(input logic [2:0] f, input logic [6:0] cs, input logic [0:35] dout,
                          input int dly, input logic respond, input logic [0:35] din,
                          input logic pgood, input int gdelay, input logic dup_req,
                          input logic drop_grant, input logic exp_to, input logic exp_pe);
    exp_t e;
    int   n, d0;
    logic wr;
    wr = (f == EBUS_CONO) || (f == EBUS_DATAO);
    e.rd = !wr;
    e.data = (exp_to || wr) ? 36'o0 : din;
    e.to = exp_to;
    e.pe = exp_pe;
    sb_q.push_back(e);
    dev_en = respond;
    dev_delay = dly;
    dev_data = din;
    dev_par = pgood ? ~(^din) : (^din);
    d0 = done_cnt;
    stable_bad = 1'b0;
    oe_seen = 1'b0;
    arb_bad = 1'b0;
    dwidth = 0;

    @(posedge clk); #1;
    ebusGrant = (gdelay == 0);
    ioFunc = f; ioCS = cs; ioDataOut = dout; ioReq = 1'b1;
    @(posedge clk); #1;
    ioReq = 1'b0;
    lat = 1;
    for (int i = 0; i < gdelay; i++) begin
      if (ebusCS != 7'd0 || ebusFunc != 3'd0 || ebusDemand || !ebusReq) arb_bad = 1'b1;
      if (dup_req && i == 3) begin
        ioReq = 1'b1; ioFunc = EBUS_CONO; ioCS = 7'o177;
      end else begin
        ioReq = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    ioReq = 1'b0;
    ebusGrant = 1'b1;

    n = 0;
    while (!ebusDemand && n < 100) begin
      if (ebusDataOE) oe_seen = 1'b1;
      @(posedge clk); #1;
      lat++; n++;
    end
    chk("demand_latency", 64'(lat), 64'(gdelay + 2 + SETUP));

    n = 0;
    while (!ioDone && n < 1000) begin
      if (ebusDataOE) oe_seen = 1'b1;
      if (ebusDemand) begin
        dwidth++;
        if (drop_grant) ebusGrant = 1'b0;
        if (ebusCS !== cs || ebusFunc !== f || ebusDataOE !== wr ||
            ebusDataOut !== (wr ? dout : 36'o0)) stable_bad = 1'b1;
`ifdef EBUS_PARITY_EN
        if (ebusParOut !== (wr ? ~(^dout) : 1'b0)) stable_bad = 1'b1;
`endif
      end
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 64'(ioDone), 64'(1));
    chk("bus_stable", 64'(stable_bad), 64'(0));
    chk("oe_seen", 64'(oe_seen), 64'(wr));
    ebusGrant = 1'b1;
    @(posedge clk); #1;
    chk("busy_clear", 64'(ioBusy), 64'(0));
    repeat (3) @(posedge clk); #1;
    chk("one_done", 64'(done_cnt - d0), 64'(1));
    $display("xfer func=%0d cs=%o dout=%o dly=%0d lat=%0d demand_clks=%0d",
             f, cs, dout, dly, lat, dwidth);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    rst_n = 1'b0;
    ioReq = 1'b0; ioFunc = '0; ioCS = '0; ioDataOut = '0; ebusGrant = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", 64'(any_out()), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_outputs", 64'(any_out()), 64'(0));

    // 1: DATAO, XFER 3 clocks after DEMAND
    run_xfer(EBUS_DATAO, 7'o040, 36'o123456701234, 3, 1'b1, 36'o0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 2: DATAI, grant dropped during DEMAND (must be ignored)
    run_xfer(EBUS_DATAI, 7'o004, 36'o0, 1, 1'b1, 36'o777000111222, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    // CONI with XFER raised as soon as DEMAND appears
    run_xfer(EBUS_CONI, 7'o070, 36'o0, 0, 1'b1, 36'o400000000001, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 3: CONO and CONI timeouts
    run_xfer(EBUS_CONO, 7'o010, 36'o000000777777, 0, 1'b0, 36'o0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("cono_demand_width", 64'(dwidth), 64'(TIMEOUT));
    run_xfer(EBUS_CONI, 7'o011, 36'o0, 0, 1'b0, 36'o525252525252, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("coni_demand_width", 64'(dwidth), 64'(TIMEOUT));
    // XFER synchronised in the last timeout clock wins; one clock later loses
    run_xfer(EBUS_DATAI, 7'o020, 36'o0, TIMEOUT - 3, 1'b1, 36'o000555000555, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("xfer_wins_width", 64'(dwidth), 64'(TIMEOUT));
    run_xfer(EBUS_DATAI, 7'o021, 36'o0, TIMEOUT - 2, 1'b1, 36'o000555000555, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("late_xfer_width", 64'(dwidth), 64'(TIMEOUT));
    // 4: grant withheld 10 clocks, duplicate request while busy
    run_xfer(EBUS_DATAO, 7'o055, 36'o707070707070, 2, 1'b1, 36'o0, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("no_bus_before_grant", 64'(arb_bad), 64'(0));

    // 5: reset while DEMAND is high
    @(posedge clk); #1;
    dev_en = 1'b0;
    ioFunc = EBUS_DATAO; ioCS = 7'o012; ioDataOut = 36'o111111111111; ioReq = 1'b1;
    @(posedge clk); #1;
    ioReq = 1'b0;
    n = 0;
    while (!ebusDemand && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_demand_seen", 64'(ebusDemand), 64'(1));
    repeat (3) @(posedge clk);
    #3;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_midcycle_zero", 64'(any_out()), 64'(0));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_no_done", 64'(done_cnt - d0), 64'(0));
    run_xfer(EBUS_DATAO, 7'o012, 36'o222222222222, 1, 1'b1, 36'o0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef EBUS_PARITY_EN
    // 6: read parity, bad then good
    run_xfer(EBUS_DATAI, 7'o030, 36'o0, 1, 1'b1, 36'o123123123123, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_xfer(EBUS_DATAI, 7'o030, 36'o0, 1, 1'b1, 36'o123123123123, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    repeat (5) @(posedge clk); #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
